// File: rtl/access_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module   : access_ctrl_fsm_param
// Purpose  : RAM-backed password gate with login, password change, failure
//            counting and timed lockout. All outputs are registered.
// Revision : 1.0
// ============================================================================
module access_ctrl_fsm_param #(
  parameter int PW_W           = 16,
  parameter int ADDR_W         = 16,
  parameter int MAX_FAILS      = 4,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int MEM_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PW_W-1:0]   data_in,
  input  logic              data_in_load,
  input  logic [1:0]        mode_in,
  input  logic              logout,
  input  logic [PW_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [PW_W-1:0]   mem_wdata,
  output logic              access_grant,
  output logic              locked,
  output logic              busy,
  output logic              err,
  output logic [3:0]        fail_count
);

  localparam int c_LAT_W  = $clog2(MEM_LAT + 1);
  localparam int c_LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;

  localparam logic [c_LAT_W-1:0]  c_LAT_LAST  = c_LAT_W'(MEM_LAT);
  localparam logic [c_LAT_W-1:0]  c_LAT_ONE   = c_LAT_W'(1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_LOAD = c_LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_ONE  = c_LOCK_W'(1);
  localparam logic [3:0]          c_MAX_FAILS = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_GET_PW  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_GRANTED = 3'd4,
    ST_GET_NEW = 3'd5,
    ST_WRITE   = 3'd6,
    ST_LOCKOUT = 3'd7
  } state_t;

  state_t              r_state,     w_state;
  logic [c_LAT_W-1:0]  r_lat_cnt,   w_lat_cnt;
  logic [c_LOCK_W-1:0] r_lock_cnt,  w_lock_cnt;
  logic [ADDR_W-1:0]   r_addr,      w_addr;
  logic                r_change,    w_change;
  logic [PW_W-1:0]     r_stored_pw, w_stored_pw;
  logic [PW_W-1:0]     r_user_pw,   w_user_pw;
  logic [PW_W-1:0]     r_wdata,     w_wdata;
  logic [3:0]          r_fails,     w_fails;
  logic                r_err,       w_err;
  logic                r_grant,     w_grant;
  logic                r_locked,    w_locked;
  logic                r_busy,      w_busy;
  logic                r_wren,      w_wren;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      r_lock_cnt  <= '0;
      r_addr      <= '0;
      r_change    <= 1'b0;
      r_stored_pw <= '0;
      r_user_pw   <= '0;
      r_wdata     <= '0;
      r_fails     <= '0;
      r_err       <= 1'b0;
      r_grant     <= 1'b0;
      r_locked    <= 1'b0;
      r_busy      <= 1'b0;
      r_wren      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lat_cnt   <= w_lat_cnt;
      r_lock_cnt  <= w_lock_cnt;
      r_addr      <= w_addr;
      r_change    <= w_change;
      r_stored_pw <= w_stored_pw;
      r_user_pw   <= w_user_pw;
      r_wdata     <= w_wdata;
      r_fails     <= w_fails;
      r_err       <= w_err;
      r_grant     <= w_grant;
      r_locked    <= w_locked;
      r_busy      <= w_busy;
      r_wren      <= w_wren;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_lat_cnt   = r_lat_cnt;
    w_lock_cnt  = r_lock_cnt;
    w_addr      = r_addr;
    w_change    = r_change;
    w_stored_pw = r_stored_pw;
    w_user_pw   = r_user_pw;
    w_wdata     = r_wdata;
    w_fails     = r_fails;
    w_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (data_in_load) begin
          if (mode_in[1]) begin
            w_err = 1'b1;
          end else begin
            w_addr    = data_in[ADDR_W-1:0];
            w_change  = mode_in[0];
            w_fails   = '0;
            w_lat_cnt = '0;
            w_state   = ST_READ;
          end
        end
      end

      // mem_addr becomes valid one cycle into READ, so the capture lands
      // MEM_LAT cycles after the RAM first sees the address.
      ST_READ: begin
        if (r_lat_cnt == c_LAT_LAST) begin
          w_stored_pw = mem_rdata;
          w_state     = ST_GET_PW;
        end else begin
          w_lat_cnt = r_lat_cnt + c_LAT_ONE;
        end
      end

      ST_GET_PW: begin
        if (data_in_load) begin
          w_user_pw = data_in;
          w_state   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (r_user_pw == r_stored_pw) begin
          w_state = r_change ? ST_GET_NEW : ST_GRANTED;
        end else begin
          w_err   = 1'b1;
          w_fails = r_fails + 4'd1;
          if (w_fails == c_MAX_FAILS) begin
            w_lock_cnt = c_LOCK_LOAD;
            w_state    = ST_LOCKOUT;
          end else begin
            w_state = ST_GET_PW;
          end
        end
      end

      ST_GRANTED: begin
        if (logout) begin
          w_fails = '0;
          w_state = ST_IDLE;
        end
      end

      ST_GET_NEW: begin
        if (data_in_load) begin
          w_wdata = data_in;
          w_state = ST_WRITE;
        end
      end

      ST_WRITE: begin
        w_state = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_fails = '0;
          w_state = ST_IDLE;
        end else begin
          w_lock_cnt = r_lock_cnt - c_LOCK_ONE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they change on the
    // same edge as the state itself.
    w_grant  = (w_state == ST_GRANTED);
    w_locked = (w_state == ST_LOCKOUT);
    w_busy   = (w_state != ST_IDLE);
    w_wren   = (w_state == ST_WRITE);
  end

  assign mem_addr     = r_addr;
  assign mem_wren     = r_wren;
  assign mem_wdata    = r_wdata;
  assign access_grant = r_grant;
  assign locked       = r_locked;
  assign busy         = r_busy;
  assign err          = r_err;
  assign fail_count   = r_fails;

endmodule
`default_nettype wire
